// File: rtl/mod_seq_counter.sv
// mod_seq_counter: modulo sequence counter with run-time limit, up/down/ping-pong/hold modes and wrap reporting
module mod_seq_counter #(
  parameter int WIDTH     = 2,
  parameter int RESET_VAL = 0,
  parameter int WCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  res,
  output logic              wrap,
  output logic              dir,
  output logic [WCNT_W-1:0] wrap_cnt
);
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_dir;
  logic             nxt_wrap;
  logic             step;
  assign step = en && (mode != 2'd3);
  always_comb begin
    nxt_res  = res;
    nxt_dir  = dir;
    nxt_wrap = 1'b0;
    if (clr) begin
      nxt_res = '0;
      nxt_dir = 1'b0;
    end else if (load) begin
      nxt_res = (load_val > limit) ? limit : load_val;
    end else if (step) begin
      // res above limit means limit was lowered under us: resync without a wrap event
      if (res > limit) begin
        nxt_res = (mode == 2'd1) ? limit : '0;
        nxt_dir = (mode == 2'd1) ? dir : 1'b0;
      end else if (limit == '0) begin
        nxt_res  = '0;
        nxt_dir  = 1'b0;
        nxt_wrap = 1'b1;
      end else if (mode == 2'd0) begin
        nxt_res  = (res == limit) ? '0 : res + 1'b1;
        nxt_wrap = (res == limit);
      end else if (mode == 2'd1) begin
        nxt_res  = (res == '0) ? limit : res - 1'b1;
        nxt_wrap = (res == '0);
      end else begin
        nxt_wrap = dir ? (res == '0) : (res == limit);
        nxt_dir  = nxt_wrap ? ~dir : dir;
        nxt_res  = nxt_dir ? res - 1'b1 : res + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res      <= WIDTH'(RESET_VAL);
      wrap     <= 1'b0;
      dir      <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      res      <= nxt_res;
      wrap     <= nxt_wrap;
      dir      <= nxt_dir;
      wrap_cnt <= clr ? '0 : (nxt_wrap && !(&wrap_cnt)) ? wrap_cnt + 1'b1 : wrap_cnt;
    end
  end
endmodule

// File: tb/tb_mod_seq_counter.sv
// tb_mod_seq_counter: directed checks of a 4-bit counter and a 2-bit counter with a 2-bit wrap counter
module tb_mod_seq_counter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, clr, load;
  logic [3:0] load_val, limit;
  logic [1:0] mode;
  logic [3:0] res;
  logic       wrap, dir;
  logic [7:0] wrap_cnt;
  logic       en_b, clr_b, load_b;
  logic [1:0] load_val_b, limit_b, mode_b;
  logic [1:0] res_b;
  logic       wrap_b, dir_b;
  logic [1:0] wrap_cnt_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_seq_counter #(.WIDTH(4), .RESET_VAL(0), .WCNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .mode(mode),
    .res(res), .wrap(wrap), .dir(dir), .wrap_cnt(wrap_cnt)
  );

  mod_seq_counter #(.WIDTH(2), .RESET_VAL(2), .WCNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .clr(clr_b), .load(load_b),
    .load_val(load_val_b), .limit(limit_b), .mode(mode_b),
    .res(res_b), .wrap(wrap_b), .dir(dir_b), .wrap_cnt(wrap_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int r, input int w, input int d);
    chk({tag, " res"}, 32'(res), r);
    chk({tag, " wrap"}, 32'(wrap), w);
    chk({tag, " dir"}, 32'(dir), d);
  endtask

  initial begin
    int pp_res [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    int pp_dir [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int dn_res [5]  = '{2, 1, 0, 9, 8};
    int up_res [6]  = '{1, 2, 0, 1, 2, 0};
    reset_n = 1'b0;
    {en, clr, load, load_val, limit, mode} = '0;
    {en_b, clr_b, load_b, load_val_b, limit_b, mode_b} = '0;
    step();
    step();
    chk_a("reset_a", 0, 0, 0);
    chk("reset_a wrap_cnt", 32'(wrap_cnt), 0);
    chk("reset_b res", 32'(res_b), 2);
    reset_n = 1'b1;
    // 2-bit counter: clear away RESET_VAL, then wrap-up over 0..2
    clr_b = 1'b1;
    step();
    chk("b clr res", 32'(res_b), 0);
    clr_b = 1'b0; limit_b = 2'd2; mode_b = 2'd0; en_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b up res %0d", i), 32'(res_b), up_res[i]);
      chk($sformatf("b up wrap %0d", i), 32'(wrap_b), (up_res[i] == 0) ? 1 : 0);
    end
    chk("b up wrap_cnt", 32'(wrap_cnt_b), 2);
    limit_b = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("b lim0 res %0d", i), 32'(res_b), 0);
      chk($sformatf("b lim0 wrap %0d", i), 32'(wrap_b), 1);
    end
    chk("b wrap_cnt saturated", 32'(wrap_cnt_b), 3);
    en_b = 1'b0;
    // 4-bit ping-pong over 0..5
    limit = 4'd5; mode = 2'd2; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk_a($sformatf("pp %0d", i), pp_res[i], (i == 5 || i == 10) ? 1 : 0, pp_dir[i]);
    end
    chk("pp wrap_cnt", 32'(wrap_cnt), 2);
    // load then count down over 0..9
    limit = 4'd9; mode = 2'd1; load_val = 4'd3; load = 1'b1;
    step();
    chk_a("dn load", 3, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("dn %0d", i), dn_res[i], (i == 3) ? 1 : 0, 0);
    end
    chk("dn wrap_cnt", 32'(wrap_cnt), 3);
    // out-of-range recovery and clamped load
    load_val = 4'd7; load = 1'b1; en = 1'b0;
    step();
    chk("load 7", 32'(res), 7);
    load = 1'b0; limit = 4'd4; mode = 2'd0; en = 1'b1;
    step();
    chk_a("oor up", 0, 0, 0);
    load_val = 4'd12; load = 1'b1;
    step();
    chk("load clamp", 32'(res), 4);
    load = 1'b0; limit = 4'd2; mode = 2'd1;
    step();
    chk_a("oor down", 2, 0, 0);
    // clr beats load and en
    limit = 4'd9; load_val = 4'd5; load = 1'b1; en = 1'b0;
    step();
    chk("load 5", 32'(res), 5);
    clr = 1'b1; en = 1'b1;
    step();
    chk_a("clr prio", 0, 0, 0);
    chk("clr wrap_cnt", 32'(wrap_cnt), 0);
    clr = 1'b0; load = 1'b0; limit = 4'd0; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("lim0 %0d", i), 0, 1, 0);
    end
    chk("lim0 wrap_cnt", 32'(wrap_cnt), 3);
    // hold mode ignores en
    limit = 4'd9; load_val = 4'd4; load = 1'b1; en = 1'b0;
    step();
    load = 1'b0; mode = 2'd3; en = 1'b1;
    step();
    chk_a("hold", 4, 0, 0);
    // async reset between edges, with wrap high
    clr = 1'b1;
    step();
    clr = 1'b0; limit = 4'd4; mode = 2'd1;
    step();
    chk_a("pre reset", 4, 1, 0);
    en = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk_a("async reset", 0, 0, 0);
    chk("async reset wrap_cnt", 32'(wrap_cnt), 0);
    chk("async reset b res", 32'(res_b), 2);
    chk("async reset b wrap_cnt", 32'(wrap_cnt_b), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_seq_counter.md
Name: mod_seq_counter

Overview:
Parametrised modulo sequence counter. It generalises the fixed 0->1->2->0 cycling register to a WIDTH-bit count with a run-time limit, four run modes, sync clear and load, and wrap/turn event reporting. It is used as a phase/slot sequencer feeding pmux-style decode logic elsewhere in the design. The count output is registered.

Parameters:
WIDTH, 2, count width in bits (>=1)
RESET_VAL, 0, value of res after reset; must be < 2**WIDTH
WCNT_W, 8, width of the saturating wrap-event counter

Ports:
clk  in  1  clock, all state changes on posedge
reset_n  in  1  asynchronous active-low reset
en  in  1  advance one step this cycle
clr  in  1  synchronous clear to 0
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value for load
limit  in  WIDTH  highest count value; sequence spans 0..limit
mode  in  2  0=wrap up, 1=wrap down, 2=ping-pong, 3=hold
res  out  WIDTH  current count (registered)
wrap  out  1  one-cycle pulse: wrap or ping-pong turn occurred on this update
dir  out  1  current ping-pong direction, 0=up 1=down
wrap_cnt  out  WCNT_W  saturating count of wrap pulses

Behaviour:
- Reset (reset_n=0, async): res=RESET_VAL, wrap=0, dir=0, wrap_cnt=0. Release is sampled on the next posedge.
- Priority per cycle: clr > load > en. With none of these asserted, or with mode=3, state holds and wrap=0.
- clr: res=0, dir=0, wrap=0. wrap_cnt is also cleared.
- load: res=min(load_val, limit), dir unchanged, wrap=0.
- Mode 0 (up): res==limit -> 0 with wrap=1; else res+1.
- Mode 1 (down): res==0 -> limit with wrap=1; else res-1.
- Mode 2 (ping-pong):
  - dir=0, res<limit: res+1.
  - dir=0, res==limit: res-1, dir=1, wrap=1.
  - dir=1, res>0: res-1.
  - dir=1, res==0: res+1, dir=0, wrap=1.
- limit==0, any counting mode: res stays 0, wrap=1 on every enabled step, dir forced to 0.
- limit==1, ping-pong: sequence 0,1,0,1 with wrap on every step.
- Out-of-range (res>limit, e.g. limit lowered mid-run), on an enabled step:
  - modes 0 and 2: res=0, dir=0, wrap=0.
  - mode 1: res=limit, wrap=0.
- Mode change mid-run takes effect on the next enabled step from the current res. dir is ignored outside mode 2 but retains its value.
- wrap is registered and is high exactly in the cycle after the update that produced it. wrap_cnt increments with each wrap and saturates at all-ones.
- All arithmetic is modulo 2**WIDTH. No wrap through 2**WIDTH-1 is possible because res<=limit is enforced.
- Reset asserted mid-sequence returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
- WIDTH=2, limit=2, mode=0, en=1 after reset -> res 0,1,2,0,1,2; wrap high in the cycles where res returns to 0; wrap_cnt=2 after 6 steps.
- WIDTH=4, limit=5, mode=2, en=1 -> res 0,1,2,3,4,5,4,3,2,1,0,1; dir 0->1 at the turn from 5, 1->0 at the turn from 0; two wrap pulses.
- WIDTH=4, limit=9, mode=1, load_val=3 with load=1, then en=1 -> res 3,2,1,0,9,8; wrap on 0->9.
- res=7, limit changed to 4, mode=0, en=1 -> res=0, wrap=0; load_val=12 with limit=4 -> res=4.
- clr and load and en asserted together with res=5 -> res=0, wrap_cnt=0. limit=0, mode=0, en=1 for 3 cycles -> res=0 throughout, wrap=1 each cycle, wrap_cnt=3.
- Drive reset_n low between clock edges at res=4 -> res=RESET_VAL and wrap=0 immediately. WCNT_W=2 with 5 wraps -> wrap_cnt holds at 3.
